// File: rtl/pipe_pkg.sv
// Shared constants for the decode/execute boundary: widths and the
// bit positions inside the 8-bit control word.
package pipe_pkg;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int CNT_W  = 16;
   localparam int CTRL_W = 8;

   localparam int CTRL_REG_WRITE = 7;
   localparam int CTRL_MEM_READ  = 6;
   localparam int CTRL_MEM_WRITE = 5;
   localparam int CTRL_ALU_SRC   = 4;
   localparam int ALU_OP_HI      = 3;
   localparam int ALU_OP_LO      = 0;

   typedef logic [CTRL_W-1:0] ctrl_t;
endpackage

// File: rtl/id_ex_stage_if.sv
// Signal bundle between the decode/writeback/EX-MEM side (master) and
// the ID/EX stage (slave).
interface id_ex_stage_if #(
   parameter int DATA_W = pipe_pkg::DATA_W,
   parameter int ADDR_W = pipe_pkg::ADDR_W,
   parameter int CNT_W  = pipe_pkg::CNT_W
);
   logic              id_valid;
   logic [ADDR_W-1:0] id_rs;
   logic [ADDR_W-1:0] id_rt;
   logic [ADDR_W-1:0] id_rd;
   logic              id_use_rt;
   logic [DATA_W-1:0] id_rf_data0;
   logic [DATA_W-1:0] id_rf_data1;
   logic [DATA_W-1:0] id_imm;
   logic [7:0]        id_ctrl;
   logic              id_flush;
   logic              wb_wr_n;
   logic [ADDR_W-1:0] wb_addr;
   logic [DATA_W-1:0] wb_data;
   logic              exm_reg_write;
   logic [ADDR_W-1:0] exm_rd;
   logic [DATA_W-1:0] exm_result;
   logic              stall;
   logic              ex_valid;
   logic [7:0]        ex_ctrl;
   logic [ADDR_W-1:0] ex_rd;
   logic [DATA_W-1:0] ex_imm;
   logic [DATA_W-1:0] ex_op_a;
   logic [DATA_W-1:0] ex_op_b;
   logic [DATA_W-1:0] ex_store_data;
   logic [CNT_W-1:0]  stall_count;

   modport master (
      output id_valid, id_rs, id_rt, id_rd, id_use_rt, id_rf_data0, id_rf_data1,
             id_imm, id_ctrl, id_flush, wb_wr_n, wb_addr, wb_data,
             exm_reg_write, exm_rd, exm_result,
      input  stall, ex_valid, ex_ctrl, ex_rd, ex_imm, ex_op_a, ex_op_b,
             ex_store_data, stall_count
   );

   modport slave (
      input  id_valid, id_rs, id_rt, id_rd, id_use_rt, id_rf_data0, id_rf_data1,
             id_imm, id_ctrl, id_flush, wb_wr_n, wb_addr, wb_data,
             exm_reg_write, exm_rd, exm_result,
      output stall, ex_valid, ex_ctrl, ex_rd, ex_imm, ex_op_a, ex_op_b,
             ex_store_data, stall_count
   );
endinterface

// File: rtl/fwd_mux.sv
// Operand bypass for one EX source register: EX/MEM result beats
// writeback data, which beats the value captured at decode.
module fwd_mux #(
   parameter int DATA_W = pipe_pkg::DATA_W,
   parameter int ADDR_W = pipe_pkg::ADDR_W
) (
   input  logic [ADDR_W-1:0] src,
   input  logic [DATA_W-1:0] reg_val,
   input  logic              exm_reg_write,
   input  logic [ADDR_W-1:0] exm_rd,
   input  logic [DATA_W-1:0] exm_result,
   input  logic              wb_wr_n,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   output logic [DATA_W-1:0] val
);
   logic exm_hit, wb_hit;

   assign exm_hit = exm_reg_write && (exm_rd != '0) && (exm_rd == src);
   assign wb_hit  = !wb_wr_n && (wb_addr != '0) && (wb_addr == src);

   always_comb begin
      val = reg_val;
      if (exm_hit)     val = exm_result;
      else if (wb_hit) val = wb_data;
   end
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with register-file write-through at capture,
// EX operand forwarding, load-use stall/bubble and a stall-cycle counter.
module id_ex_stage #(
   parameter int DATA_W = pipe_pkg::DATA_W,
   parameter int ADDR_W = pipe_pkg::ADDR_W,
   parameter int CNT_W  = pipe_pkg::CNT_W
) (
   input logic         clk,
   input logic         rst,
   id_ex_stage_if.slave bus
);
   import pipe_pkg::*;

   logic              ex_valid;
   ctrl_t             ex_ctrl;
   logic [ADDR_W-1:0] ex_rd, ex_rs, ex_rt;
   logic [DATA_W-1:0] ex_imm, ex_a, ex_b;
   logic [CNT_W-1:0]  stall_cnt;
   logic [DATA_W-1:0] cap_a, cap_b, fwd_a, fwd_b;
   logic              hz, stall;

   // The register file returns pre-write data, so a same-cycle write must be patched in here.
   always_comb begin
      cap_a = bus.id_rf_data0;
      cap_b = bus.id_rf_data1;
      if (!bus.wb_wr_n && bus.wb_addr == bus.id_rs) cap_a = bus.wb_data;
      if (!bus.wb_wr_n && bus.wb_addr == bus.id_rt) cap_b = bus.wb_data;
      if (bus.id_rs == '0) cap_a = '0;
      if (bus.id_rt == '0) cap_b = '0;
   end

   assign hz = ex_valid && ex_ctrl[CTRL_MEM_READ] && (ex_rd != '0) && bus.id_valid &&
               ((ex_rd == bus.id_rs) || (bus.id_use_rt && ex_rd == bus.id_rt));
   assign stall = hz && !bus.id_flush;

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid <= 1'b0;
         ex_ctrl  <= '0;
         ex_rd    <= '0;
         ex_rs    <= '0;
         ex_rt    <= '0;
         ex_imm   <= '0;
         ex_a     <= '0;
         ex_b     <= '0;
      end else if (bus.id_flush || stall) begin
         ex_valid <= 1'b0;
         ex_ctrl  <= '0;
      end else begin
         ex_valid <= bus.id_valid;
         ex_ctrl  <= bus.id_valid ? bus.id_ctrl : '0;
         ex_rd    <= bus.id_rd;
         ex_rs    <= bus.id_rs;
         ex_rt    <= bus.id_rt;
         ex_imm   <= bus.id_imm;
         ex_a     <= cap_a;
         ex_b     <= cap_b;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)                                    stall_cnt <= '0;
      else if (stall && stall_cnt != {CNT_W{1'b1}}) stall_cnt <= stall_cnt + CNT_W'(1);
   end

   fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd_a (
      .src(ex_rs), .reg_val(ex_a),
      .exm_reg_write(bus.exm_reg_write), .exm_rd(bus.exm_rd), .exm_result(bus.exm_result),
      .wb_wr_n(bus.wb_wr_n), .wb_addr(bus.wb_addr), .wb_data(bus.wb_data),
      .val(fwd_a)
   );

   fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd_b (
      .src(ex_rt), .reg_val(ex_b),
      .exm_reg_write(bus.exm_reg_write), .exm_rd(bus.exm_rd), .exm_result(bus.exm_result),
      .wb_wr_n(bus.wb_wr_n), .wb_addr(bus.wb_addr), .wb_data(bus.wb_data),
      .val(fwd_b)
   );

   assign bus.stall         = stall;
   assign bus.ex_valid      = ex_valid;
   assign bus.ex_ctrl       = ex_ctrl;
   assign bus.ex_rd         = ex_rd;
   assign bus.ex_imm        = ex_imm;
   assign bus.ex_op_a       = fwd_a;
   assign bus.ex_op_b       = ex_ctrl[CTRL_ALU_SRC] ? ex_imm : fwd_b;
   assign bus.ex_store_data = fwd_b;
   assign bus.stall_count   = stall_cnt;
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline stage directly downstream of the 32x32 register file. It captures both read-port outputs plus decode fields into the ID/EX pipeline register.
- Patches same-cycle writeback hazards, because the register file reads old data before the write edge.
- Drives forwarded ALU operands into EX.
- Detects load-use hazards, stalls IF/ID, and inserts a bubble; also counts stall cycles.

Parameters:
- DATA_W, 32, datapath width
- ADDR_W, 5, register address width
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- id_valid  in  1  ID holds a real instruction
- id_rs  in  ADDR_W  source A address (also drives register file read0)
- id_rt  in  ADDR_W  source B address (also drives read1)
- id_rd  in  ADDR_W  destination address
- id_use_rt  in  1  instruction reads rt (0 for immediate forms)
- id_rf_data0  in  DATA_W  register file readOutput0
- id_rf_data1  in  DATA_W  register file readOutput1
- id_imm  in  DATA_W  sign-extended immediate
- id_ctrl  in  8  {reg_write, mem_read, mem_write, alu_src, alu_op[3:0]}
- id_flush  in  1  branch-taken squash of ID instruction
- wb_wr_n  in  1  register file write enable, active-low, as driven to the file
- wb_addr  in  ADDR_W  register file write address
- wb_data  in  DATA_W  register file write data
- exm_reg_write  in  1  EX/MEM will write
- exm_rd  in  ADDR_W  EX/MEM destination
- exm_result  in  DATA_W  EX/MEM ALU result
- stall  out  1  hold PC and IF/ID this cycle
- ex_valid  out  1  EX holds a real instruction
- ex_ctrl  out  8  registered control
- ex_rd  out  ADDR_W  registered destination
- ex_imm  out  DATA_W  registered immediate
- ex_op_a  out  DATA_W  forwarded operand A
- ex_op_b  out  DATA_W  forwarded operand B, or ex_imm when alu_src=1
- ex_store_data  out  DATA_W  forwarded rt value for stores
- stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset: all registered state is zero, so ex_valid=0, ex_ctrl=0, ex_rd=0, ex_imm=0, and the captured data registers are 0. stall_count=0.
- Because state is zero after reset, stall=0 and ex_op_a=ex_op_b=ex_store_data=0 unless exm_* forwarding matches register 0, which is excluded.
- Reset has priority over everything; a reset mid-stall drops the stall on the next cycle.
- Capture-time write-through, applied to each source independently:
  - If wb_wr_n==0 and wb_addr==src and src!=0, capture wb_data; otherwise capture id_rf_data*.
  - Register 0 always captures 0.
- Load-use hazard (combinational):
  - hz = ex_valid & ex_ctrl.mem_read & ex_rd!=0 & id_valid & (ex_rd==id_rs | (id_use_rt & ex_rd==id_rt)).
  - stall = hz & ~id_flush.
- Pipeline register update at each clk edge, in priority order:
  1. rst: clear all state.
  2. id_flush or stall: bubble. ex_valid=0 and ex_ctrl=0; data fields don't-care (hold).
  3. Otherwise: ex_valid=id_valid, and ex_ctrl = id_valid ? id_ctrl : 0.
- Latency: an ID instruction appears on ex_* one cycle later. A stalled instruction appears one cycle after stall drops, which is always exactly one cycle, since the bubble clears the hazard.
- EX forwarding, combinational on registered sources ex_rs/ex_rt (held internally). Priority order:
  - EX/MEM match: exm_reg_write & exm_rd!=0 & exm_rd==src, select exm_result.
  - WB match: ~wb_wr_n & wb_addr!=0 & wb_addr==src, select wb_data.
  - Otherwise select the registered captured value.
- ex_op_b = alu_src ? ex_imm : forwarded rt. ex_store_data is always the forwarded rt.
- stall_count increments on each cycle with stall=1 and saturates at all-ones.
- Simultaneous events:
  - Flush and hazard in the same cycle: flush wins and stall=0.
  - wb and exm writing the same register: exm wins (newer).
  - Stall with id_valid=0 is impossible by construction.

Decomposition:
- Shared package pipe_pkg holds:
  - ctrl bit-index constants CTRL_REG_WRITE=7, CTRL_MEM_READ=6, CTRL_MEM_WRITE=5, CTRL_ALU_SRC=4
  - ALU_OP field [3:0]
  - the width constants
- One sub-module fwd_mux selects a forwarded value from one source address; instantiated twice (rs, rt).

Test Plan:
- Reset: assert rst with id_valid=1 in the same cycle, then release. Required: ex_valid=0, ex_ctrl=0, stall=0, stall_count=0.
- Write-through: id_rs=5 with id_rf_data0=0x11, and wb_wr_n=0, wb_addr=5, wb_data=0xABCD in the same cycle. Required: next cycle ex_op_a=0xABCD with no exm match.
- EX/MEM priority: EX sources rs=3. exm_rd=3, exm_result=0x100, and wb_addr=3, wb_data=0x200 both writing. Required: ex_op_a=0x100. With exm_rd=0 instead, required: ex_op_a=0x200.
- Load-use: EX holds a load (mem_read=1) with ex_rd=7, and ID has id_rt=7, id_use_rt=1. Required: stall=1 for exactly one cycle, a bubble in EX (ex_valid=0), stall_count=1, then the instruction enters EX. Repeat with id_use_rt=0: required stall=0.
- Flush versus stall: same hazard as above plus id_flush=1. Required: stall=0, next ex_valid=0, stall_count unchanged.
- Register 0 guard: exm_reg_write=1 with exm_rd=0, exm_result=0xFFFF, EX rs=0. Required: ex_op_a=0. Then force stall_count to all-ones and keep stalling; required: it holds at 0xFFFF.
